// File: rtl/sram_axi_arbiter_pkg.sv
// Shared types and AXI constants for the SRAM-like to AXI bridge.
package sram_axi_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } axi_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

  // One SRAM-like request as seen at a core port
  typedef struct packed {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

  // Response toward a core port
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
  } sram_resp_t;

endpackage

// File: rtl/sram_strb_gen.sv
// Byte-lane strobe and AXI size from an SRAM-like size/offset pair.
module sram_strb_gen
  import sram_axi_arbiter_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr,
  output logic [3:0] wstrb,
  output logic [2:0] axsize
);

  logic [1:0] size_eff;

  // Size 3 has no meaning on a 32-bit port; treat it as a full word
  always_comb begin
    size_eff = (size == 2'd3) ? 2'd2 : size;
    axsize   = {1'b0, size_eff};
    case (size_eff)
      2'd0:    wstrb = 4'b0001 << addr;
      2'd1:    wstrb = 4'b0011 << {addr[1], 1'b0};
      default: wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sram_axi_arbiter.sv
// Serialises the inst and data SRAM-like ports onto one single-beat AXI master.
module sram_axi_arbiter
  import sram_axi_arbiter_pkg::*;
#(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  axi_state_t state, state_nxt;
  sram_req_t  inst_q, data_q, lat;
  sram_resp_t inst_rsp, data_rsp;
  logic       owner_data;
  logic       aw_done, w_done;
  logic [2:0] axsize;

  // inst_wr is ignored: the fetch port only ever reads
  assign inst_q = '{req: inst_req, wr: 1'b0, size: inst_size, addr: inst_addr, wdata: inst_wdata};
  assign data_q = '{req: data_req, wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};

  sram_strb_gen u_strb (
    .size   (lat.size),
    .addr   (lat.addr[1:0]),
    .wstrb  (wstrb),
    .axsize (axsize)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Latch the granted request; track per-channel write handshakes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat        <= '0;
      owner_data <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
    end else if (state == IDLE) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      if (data_req || inst_req) begin
        owner_data <= data_req;
        lat        <= data_req ? data_q : inst_q;
      end
    end else if (state == WR_REQ) begin
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready)   w_done  <= 1'b1;
    end
  end

  // Next state and handshake outputs; addr_ok is held low while rst is up
  always_comb begin
    state_nxt = state;
    inst_rsp  = '{addr_ok: 1'b0, data_ok: 1'b0, rdata: rdata};
    data_rsp  = '{addr_ok: 1'b0, data_ok: 1'b0, rdata: rdata};
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (data_req) begin
            data_rsp.addr_ok = 1'b1;
            state_nxt        = data_wr ? WR_REQ : RD_ADDR;
          end else if (inst_req) begin
            inst_rsp.addr_ok = 1'b1;
            state_nxt        = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          if (owner_data) data_rsp.data_ok = 1'b1;
          else            inst_rsp.data_ok = 1'b1;
          state_nxt = IDLE;
        end
      end
      WR_REQ: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) begin
          data_rsp.data_ok = 1'b1;
          state_nxt        = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign inst_addr_ok = inst_rsp.addr_ok;
  assign inst_data_ok = inst_rsp.data_ok;
  assign inst_rdata   = inst_rsp.rdata;
  assign data_addr_ok = data_rsp.addr_ok;
  assign data_data_ok = data_rsp.data_ok;
  assign data_rdata   = data_rsp.rdata;

  assign arid    = owner_data ? DATA_ID : INST_ID;
  assign araddr  = lat.addr;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = axsize;
  assign arburst = AXI_BURST_INCR;
  assign awid    = owner_data ? DATA_ID : INST_ID;
  assign awaddr  = lat.addr;
  assign awlen   = AXI_LEN_SINGLE;
  assign awsize  = axsize;
  assign awburst = AXI_BURST_INCR;
  assign wdata   = lat.wdata;
  assign wlast   = 1'b1;

  // Response IDs/status and rlast are not used by a single-outstanding bridge
  logic unused_ok;
  assign unused_ok = ^{inst_wr, rid, rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Directed bench for sram_axi_arbiter: inputs change at negedge, outputs checked 1ns later.
module tb_sram_axi_arbiter;

  logic        clk, rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic [3:0]  arid, awid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  int checks = 0;
  int failures = 0;

  sram_axi_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; inst_req = 0; inst_wr = 0; inst_size = 2; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 2; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    #1 rst = 1'b1;
    #3;
    checks++; if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin failures++; $display("FAIL rst_valid_ready got=%b exp=00000", {arvalid, awvalid, wvalid, rready, bready}); end
    checks++; if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 4'b0) begin failures++; $display("FAIL rst_ok got=%b exp=0000", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}); end
    checks++; if ({araddr, awaddr, wdata} !== 96'h0) begin failures++; $display("FAIL rst_addr_data got=%h exp=0", {araddr, awaddr, wdata}); end
    checks++; if (arid !== 4'd0) begin failures++; $display("FAIL rst_arid got=%h exp=0", arid); end
    cyc(); cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_inst_read();
    inst_req = 1; inst_addr = 32'hBFC00000; inst_size = 2;
    #1;
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin failures++; $display("FAIL ir_addr_ok got=%b exp=10", {inst_addr_ok, data_addr_ok}); end
    cyc(); inst_req = 0; arready = 1; #1;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'hBFC00000 || arid !== 4'd0) begin failures++; $display("FAIL ir_ar got=%b/%h/%h exp=1/bfc00000/0", arvalid, araddr, arid); end
    checks++; if (arsize !== 3'd2 || arlen !== 8'd0 || arburst !== 2'b01) begin failures++; $display("FAIL ir_ar_fixed got=%h/%h/%h exp=2/0/1", arsize, arlen, arburst); end
    checks++; if (inst_data_ok !== 1'b0) begin failures++; $display("FAIL ir_early_ok got=%b exp=0", inst_data_ok); end
    cyc(); arready = 0; rvalid = 1; rdata = 32'h3C1D0000; #1;
    checks++; if (rready !== 1'b1 || inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin failures++; $display("FAIL ir_r got=%b/%b/%b exp=1/1/0", rready, inst_data_ok, data_data_ok); end
    checks++; if (inst_rdata !== 32'h3C1D0000) begin failures++; $display("FAIL ir_rdata got=%h exp=3c1d0000", inst_rdata); end
    cyc(); rvalid = 0; #1;
    checks++; if ({arvalid, rready, inst_data_ok} !== 3'b0) begin failures++; $display("FAIL ir_idle got=%b exp=000", {arvalid, rready, inst_data_ok}); end
  endtask

  task automatic test_priority();
    inst_req = 1; inst_addr = 32'hBFC00004; data_req = 1; data_wr = 0; data_addr = 32'h80001000; data_size = 2;
    #1;
    checks++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin failures++; $display("FAIL pr_grant got=%b exp=10", {data_addr_ok, inst_addr_ok}); end
    cyc(); data_req = 0; arready = 1; #1;
    checks++; if (arid !== 4'd1 || araddr !== 32'h80001000 || inst_addr_ok !== 1'b0) begin failures++; $display("FAIL pr_ar got=%h/%h/%b exp=1/80001000/0", arid, araddr, inst_addr_ok); end
    cyc(); arready = 0; rvalid = 1; rdata = 32'h12345678; #1;
    checks++; if ({data_data_ok, inst_data_ok, inst_addr_ok} !== 3'b100) begin failures++; $display("FAIL pr_dok got=%b exp=100", {data_data_ok, inst_data_ok, inst_addr_ok}); end
    checks++; if (data_rdata !== 32'h12345678) begin failures++; $display("FAIL pr_rdata got=%h exp=12345678", data_rdata); end
    cyc(); rvalid = 0; #1;
    checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL pr_inst_grant got=%b exp=1", inst_addr_ok); end
    cyc(); inst_req = 0; arready = 1; #1;
    checks++; if (arid !== 4'd0 || araddr !== 32'hBFC00004) begin failures++; $display("FAIL pr_inst_ar got=%h/%h exp=0/bfc00004", arid, araddr); end
    cyc(); arready = 0; rvalid = 1; rdata = 32'h00000001; #1;
    checks++; if (inst_data_ok !== 1'b1) begin failures++; $display("FAIL pr_inst_ok got=%b exp=1", inst_data_ok); end
    cyc(); rvalid = 0;
  endtask

  task automatic test_byte_write();
    data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h80000003; data_wdata = 32'hAAAAAAAA;
    #1;
    checks++; if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL bw_addr_ok got=%b exp=1", data_addr_ok); end
    cyc(); data_req = 0; data_wr = 0; awready = 1; wready = 1; #1;
    checks++; if ({awvalid, wvalid, wlast} !== 3'b111 || awid !== 4'd1) begin failures++; $display("FAIL bw_valid got=%b/%h exp=111/1", {awvalid, wvalid, wlast}, awid); end
    checks++; if (wstrb !== 4'b1000 || awsize !== 3'd0) begin failures++; $display("FAIL bw_strb got=%b/%h exp=1000/0", wstrb, awsize); end
    checks++; if (awaddr !== 32'h80000003 || wdata !== 32'hAAAAAAAA || awlen !== 8'd0 || awburst !== 2'b01) begin failures++; $display("FAIL bw_fields got=%h/%h/%h/%h exp=80000003/aaaaaaaa/0/1", awaddr, wdata, awlen, awburst); end
    cyc(); awready = 0; wready = 0; #1;
    checks++; if ({bready, data_data_ok, awvalid, wvalid} !== 4'b1000) begin failures++; $display("FAIL bw_wait_b got=%b exp=1000", {bready, data_data_ok, awvalid, wvalid}); end
    cyc(); bvalid = 1; #1;
    checks++; if (data_data_ok !== 1'b1) begin failures++; $display("FAIL bw_dok got=%b exp=1", data_data_ok); end
    cyc(); bvalid = 0; #1;
    checks++; if ({bready, data_data_ok} !== 2'b00) begin failures++; $display("FAIL bw_idle got=%b exp=00", {bready, data_data_ok}); end
  endtask

  task automatic test_write_delayed();
    data_req = 1; data_wr = 1; data_size = 1; data_addr = 32'h80000002; data_wdata = 32'h5555BEEF;
    #1;
    checks++; if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL wd_addr_ok got=%b exp=1", data_addr_ok); end
    cyc(); data_req = 0; data_wr = 0; awready = 1; #1;
    checks++; if ({awvalid, wvalid, bready} !== 3'b110 || wstrb !== 4'b1100 || awsize !== 3'd1) begin failures++; $display("FAIL wd_c1 got=%b/%b/%h exp=110/1100/1", {awvalid, wvalid, bready}, wstrb, awsize); end
    for (int i = 0; i < 2; i++) begin
      cyc(); awready = 0; #1;
      checks++; if ({awvalid, wvalid, bready} !== 3'b010) begin failures++; $display("FAIL wd_hold%0d got=%b exp=010", i, {awvalid, wvalid, bready}); end
    end
    cyc(); wready = 1; #1;
    checks++; if ({awvalid, wvalid, bready} !== 3'b010 || wdata !== 32'h5555BEEF) begin failures++; $display("FAIL wd_w got=%b/%h exp=010/5555beef", {awvalid, wvalid, bready}, wdata); end
    cyc(); wready = 0; bvalid = 1; #1;
    checks++; if ({awvalid, wvalid, bready, data_data_ok} !== 4'b0011) begin failures++; $display("FAIL wd_b got=%b exp=0011", {awvalid, wvalid, bready, data_data_ok}); end
    cyc(); bvalid = 0;
  endtask

  task automatic test_read_delayed();
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h80002008;
    #1;
    checks++; if (data_addr_ok !== 1'b1) begin failures++; $display("FAIL rd_addr_ok got=%b exp=1", data_addr_ok); end
    cyc(); data_req = 0; data_addr = 32'h0; inst_req = 1; inst_addr = 32'hBFC00100;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (arvalid !== 1'b1 || araddr !== 32'h80002008 || {inst_addr_ok, data_addr_ok} !== 2'b00) begin failures++; $display("FAIL rd_ar_wait%0d got=%b/%h/%b exp=1/80002008/00", i, arvalid, araddr, {inst_addr_ok, data_addr_ok}); end
      cyc();
    end
    arready = 1; #1;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h80002008) begin failures++; $display("FAIL rd_ar_hs got=%b/%h exp=1/80002008", arvalid, araddr); end
    cyc(); arready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if ({rready, arvalid, data_data_ok, inst_addr_ok} !== 4'b1000 || araddr !== 32'h80002008) begin failures++; $display("FAIL rd_r_wait%0d got=%b/%h exp=1000/80002008", i, {rready, arvalid, data_data_ok, inst_addr_ok}, araddr); end
      cyc();
    end
    rvalid = 1; rdata = 32'hCAFEF00D; #1;
    checks++; if ({data_data_ok, inst_data_ok, inst_addr_ok} !== 3'b100 || data_rdata !== 32'hCAFEF00D) begin failures++; $display("FAIL rd_dok got=%b/%h exp=100/cafef00d", {data_data_ok, inst_data_ok, inst_addr_ok}, data_rdata); end
    cyc(); rvalid = 0; #1;
    checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL rd_next_grant got=%b exp=1", inst_addr_ok); end
    cyc(); inst_req = 0; arready = 1;
    cyc(); arready = 0; rvalid = 1;
    cyc(); rvalid = 0;
  endtask

  task automatic test_reset_mid();
    inst_req = 1; inst_addr = 32'hBFC00010;
    cyc(); inst_req = 0; arready = 1;
    cyc(); arready = 0; #1;
    checks++; if (rready !== 1'b1) begin failures++; $display("FAIL rm_in_rdata got=%b exp=1", rready); end
    #1 rst = 1; rvalid = 1; inst_req = 1; inst_addr = 32'hBFC00020;
    #1;
    checks++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin failures++; $display("FAIL rm_vr got=%b exp=00000", {arvalid, rready, awvalid, wvalid, bready}); end
    checks++; if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 4'b0 || araddr !== 32'h0) begin failures++; $display("FAIL rm_ok got=%b/%h exp=0000/0", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, araddr); end
    cyc(); rst = 0; rvalid = 0; #1;
    checks++; if (inst_addr_ok !== 1'b1) begin failures++; $display("FAIL rm_regrant got=%b exp=1", inst_addr_ok); end
    cyc(); inst_req = 0; arready = 1; #1;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'hBFC00020) begin failures++; $display("FAIL rm_ar got=%b/%h exp=1/bfc00020", arvalid, araddr); end
    cyc(); arready = 0; rvalid = 1; rdata = 32'h0000BEEF; #1;
    checks++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h0000BEEF) begin failures++; $display("FAIL rm_dok got=%b/%h exp=1/0000beef", inst_data_ok, inst_rdata); end
    cyc(); rvalid = 0;
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_priority();
    test_byte_write();
    test_write_delayed();
    test_read_delayed();
    test_reset_mid();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
